// File: rtl/p_accum_out_if.sv
// p_accum_out_if: operand, control and result bundle for one p_accum_out slice.
interface p_accum_out_if;
  logic        CEP;
  logic        IN_VLD;
  logic [4:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] DAB;
  logic [47:0] C;
  logic [47:0] PCIN;
  logic        CIN;
  logic [47:0] P;
  logic [47:0] PCOUT;
  logic        CARRYOUT;
  logic        CARRYOUTF;
  logic        OUT_VLD;
  logic        OVF;

  modport master (
    output CEP, IN_VLD, OPMODE, M, DAB, C, PCIN, CIN,
    input  P, PCOUT, CARRYOUT, CARRYOUTF, OUT_VLD, OVF
  );

  modport slave (
    input  CEP, IN_VLD, OPMODE, M, DAB, C, PCIN, CIN,
    output P, PCOUT, CARRYOUT, CARRYOUTF, OUT_VLD, OVF
  );
endinterface

// File: rtl/p_accum_out.sv
// p_accum_out: DSP post-adder / accumulator with registered P, cascade out,
// carry out and sticky signed-overflow flag.
// Optional feature: define DSP_SAT_EN to clamp P to the signed 48-bit range on
// overflow; without it P wraps modulo 2^48.
module p_accum_out #(
  parameter int unsigned CARRYOUTREG = 1
) (
  input logic            CLK,
  input logic            RSTA,
  p_accum_out_if.slave   bus
);

  localparam int unsigned W   = 48;
  localparam int unsigned MW  = 36;
  localparam int unsigned SW  = W + 1;
  localparam int unsigned RW  = W + 2;

  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]  p_q, p_d;
  logic          co_q;
  logic          vld_q;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  x_c;
  logic [W-1:0]  z_c;
  logic          sub_c;
  logic [SW-1:0] y_c;
  logic [SW-1:0] sum_c;
  logic          carry_c;
  logic [RW-1:0] res_c;
  logic          sovf_c;
  logic          unused_res_bits;

  // Operand muxes and the 49-bit post-adder; carry is "no borrow" when subtracting
  always_comb begin
    x_c   = '0;
    z_c   = '0;
    sub_c = bus.OPMODE[4];
    unique case (bus.OPMODE[1:0])
      2'b00: x_c = '0;
      2'b01: x_c = {(W-MW)'(0), bus.M};
      2'b10: x_c = p_q;
      default: x_c = bus.DAB;
    endcase
    unique case (bus.OPMODE[3:2])
      2'b00: z_c = '0;
      2'b01: z_c = bus.PCIN;
      2'b10: z_c = p_q;
      default: z_c = bus.C;
    endcase
    y_c = {1'b0, x_c} + SW'(bus.CIN);
    if (sub_c) begin
      sum_c   = {1'b0, z_c} - y_c;
      carry_c = ~sum_c[W];
    end else begin
      sum_c   = {1'b0, z_c} + y_c;
      carry_c = sum_c[W];
    end
  end

  // Exact signed result, used only to detect leaving the signed 48-bit range
  always_comb begin
    res_c = '0;
    if (sub_c) begin
      res_c = {{2{z_c[W-1]}}, z_c} - {{2{x_c[W-1]}}, x_c} - RW'(bus.CIN);
    end else begin
      res_c = {{2{z_c[W-1]}}, z_c} + {{2{x_c[W-1]}}, x_c} + RW'(bus.CIN);
    end
    sovf_c          = ~((&res_c[RW-1:W-1]) | ~(|res_c[RW-1:W-1]));
    unused_res_bits = ^res_c[W-2:0];
  end

  // Next P (wrap or clamp) and sticky overflow update
  always_comb begin
    p_d   = sum_c[W-1:0];
`ifdef DSP_SAT_EN
    if (sovf_c) begin
      p_d = res_c[RW-1] ? NEG_MIN : POS_MAX;
    end
`endif
    ovf_d = ovf_q | (sovf_c & bus.IN_VLD);
  end

  // Result, carry, valid and overflow registers, all under CEP
  always_ff @(posedge CLK or posedge RSTA) begin
    if (RSTA) begin
      p_q   <= '0;
      co_q  <= 1'b0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.CEP) begin
      p_q   <= p_d;
      co_q  <= carry_c;
      vld_q <= bus.IN_VLD;
      ovf_q <= ovf_d;
    end
  end

  assign bus.P         = p_q;
  assign bus.PCOUT     = p_q;
  assign bus.CARRYOUT  = (CARRYOUTREG != 0) ? co_q : carry_c;
  assign bus.CARRYOUTF = bus.CARRYOUT;
  assign bus.OUT_VLD   = vld_q;
  assign bus.OVF       = ovf_q;

endmodule
